seg7_reader: RTL

Reverse path for the seven-segment display interface. It watches a time-multiplexed segment bus (segment pattern plus one-hot digit select), waits until each pattern has been stable for a set number of cycles, decodes it back to a 4-bit hex nibble, and assembles a full multi-digit word. The word is presented on a valid/ready output. It serves as the on-chip monitor that checks what the display path is actually driving, and it feeds the debug register file.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_glyph_decode.sv | 22 ++
 rtl/seg7_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment readback path.
// Glyph table is indexed by the hex value it represents.
package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h9E, 8'h7A, 8'h1A,
    8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66,
    8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps segments a..g back to a hex nibble.
// Unknown patterns yield nibble 0 with bad set.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       bad_o
);

  always_comb begin
    nib_o = 4'd0;
    bad_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == GLYPH[i][7:1]) begin
        nib_o = 4'(i);
        bad_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Monitors a multiplexed 7-seg bus, filters for stability,
// decodes each digit and presents full words on valid/ready.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [7:0]          seg_in,
  input  logic [DIGITS-1:0]   dig_sel,
  output logic [4*DIGITS-1:0] out_word,
  output logic [DIGITS-1:0]   out_dp,
  output logic [DIGITS-1:0]   out_bad,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err,
  output logic                overrun
);

  localparam logic [3:0] STB = 4'(STABLE_CYCLES);

  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] wnib_q, wnib_d;
  logic [DIGITS-1:0]   wdp_q, wdp_d;
  logic [DIGITS-1:0]   wbad_q, wbad_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] word_q, word_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   bad_q, bad_d;
  logic                err_q, err_d;
  logic                ovr_q, ovr_d;
  state_e              state_q, state_d;

  logic       match;
  logic       onehot;
  logic       capture;
  logic       complete;
  logic       load;
  logic [3:0] dec_nib;
  logic       dec_bad;

  seg7_glyph_decode u_dec (
    .seg_i (seg_q[7:1]),
    .nib_o (dec_nib),
    .bad_o (dec_bad)
  );

  assign match    = ({seg_in, dig_sel} == {seg_q, sel_q});
  assign onehot   = (sel_q != '0) &&
                    ((sel_q & (sel_q - DIGITS'(1))) == '0);
  assign capture  = match && onehot && (cnt_q == STB - 4'd1);
  assign complete = &seen_q;

  always_comb begin
    seg_d   = seg_in;
    sel_d   = dig_sel;
    cnt_d   = 4'd1;
    wnib_d  = wnib_q;
    wdp_d   = wdp_q;
    wbad_d  = wbad_q;
    seen_d  = complete ? '0 : seen_q;
    word_d  = word_q;
    dp_d    = dp_q;
    bad_d   = bad_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    state_d = state_q;
    load    = 1'b0;

    if (match) begin
      cnt_d = (cnt_q == STB) ? cnt_q : cnt_q + 4'd1;
    end

    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_q[i]) begin
          wnib_d[4*i +: 4] = dec_nib;
          wdp_d[i]         = seg_q[SEG_DP];
          wbad_d[i]        = dec_bad;
          seen_d[i]        = 1'b1;
        end
      end
      err_d = err_q | dec_bad;
    end

    unique case (state_q)
      COLLECT: begin
        if (complete) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (complete && out_ready) begin
          load = 1'b1;
        end else if (complete) begin
          ovr_d = 1'b1;
        end else if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (load) begin
      word_d = wnib_q;
      dp_d   = wdp_q;
      bad_d  = wbad_q;
    end

    // clr wins over any capture or load on the same edge
    if (clr) begin
      seg_d   = '0;
      sel_d   = '0;
      cnt_d   = 4'd0;
      wnib_d  = '0;
      wdp_d   = '0;
      wbad_d  = '0;
      seen_d  = '0;
      word_d  = '0;
      dp_d    = '0;
      bad_d   = '0;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
      state_d = COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= 4'd0;
      wnib_q  <= '0;
      wdp_q   <= '0;
      wbad_q  <= '0;
      seen_q  <= '0;
      word_q  <= '0;
      dp_q    <= '0;
      bad_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      state_q <= COLLECT;
    end else begin
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      wnib_q  <= wnib_d;
      wdp_q   <= wdp_d;
      wbad_q  <= wbad_d;
      seen_q  <= seen_d;
      word_q  <= word_d;
      dp_q    <= dp_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
    end
  end

  assign out_word  = word_q;
  assign out_dp    = dp_q;
  assign out_bad   = bad_q;
  assign out_valid = (state_q == PRESENT);
  assign err       = err_q;
  assign overrun   = ovr_q;

endmodule
